sp1_div: RTL and testbench
==========================

# sp1_div

Iterative unsigned restoring divider for the sp1 operator library. It accepts a dividend/divisor pair through a request/ready handshake and produces quotient, remainder and a divide-by-zero flag. It generates one quotient bit per clock, using a subtract-and-compare step of the same form as the library's combinational subtractor. It sits downstream of the operand-select logic and alongside the combinational sp1 operators, for the division cases the single-cycle units cannot cover.

## Interface
- DW, 8: operand and result width in bits (DW >= 2).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request; accepted on a rising edge when ready=1.
- a0  input  DW  dividend, unsigned; sampled only on the accept edge.
- a1  input  DW  divisor, unsigned; sampled only on the accept edge.
- ready  output  1  high in IDLE; combinational decode of state.
- done  output  1  one-cycle pulse; q, r and dz are valid while it is high.
- q  output  DW  quotient, registered.
- r  output  DW  remainder, registered.
- dz  output  1  divide-by-zero flag for the last completed operation, registered.

## Operation
- States: IDLE, RUN, DONE; 2-bit state register plus a step counter of clog2(DW)+1 bits.
- IDLE: ready=1. On req=1, latch a0 into the shift register, latch a1, clear the partial remainder P (DW+1 bits) and the counter, clear dz.
  - If a1 != 0, go to RUN.
  - If a1 == 0, go to DONE with q=all-ones, r=a0, dz=1.
- RUN, per edge:
  - T = {P[DW-1:0], dividend MSB} - {1'b0, divisor}, computed at DW+1 bits.
  - No borrow: P <= T and quotient bit = 1. Borrow: P <= {P[DW-1:0], dividend MSB} and quotient bit = 0.
  - The quotient bit shifts into the LSB of the dividend register, which becomes q.
  - The counter increments each step. After the DW-th step, q and r load from the working registers and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Output hold:
  - q, r and dz keep their values from the DONE cycle until the next DONE loads new ones.
  - They do not change while RUN is in progress.
- req while ready=0 (RUN or DONE) is ignored. The requester must hold req until it sees ready.
- a0/a1 changes after the accept edge have no effect.
- Reset values: state=IDLE, ready=1, done=0, q=0, r=0, dz=0, counter=0, working registers=0.
- Reset mid-operation aborts the division; no done pulse is issued.

## Timing
- The accept edge is edge 0.
- a1 != 0: RUN covers edges 1..DW. The state is DONE after edge DW, so done is high in the cycle between edge DW and edge DW+1. ready returns after edge DW+1.
- a1 == 0: done is high in the cycle between edge 0 and edge 1.
- Back-to-back throughput is one operation per DW+2 cycles; req held continuously is accepted on edge DW+2.
- The longest combinational path is one (DW+1)-bit subtract plus a mux; outputs do not depend combinationally on inputs.

## Configuration
- SP1_DIV_REM_EN defined: the remainder path is built and r carries the final P[DW-1:0], or a0 on divide-by-zero.
- SP1_DIV_REM_EN undefined: the r register is removed and the r port is tied to 0. q, dz and the timing are unchanged; P is still used internally for the restoring step.

## Test plan
- DW=8, a0=0x64, a1=0x07, req pulse at accept edge 0 -> done high between edges 8 and 9; q=0x0E, r=0x02, dz=0.
- a0=0xFF, a1=0x01 -> q=0xFF, r=0x00. a0=0x05, a1=0x09 -> q=0x00, r=0x05. a0=0xFF, a1=0xFF -> q=0x01, r=0x00.
- a0=0x2A, a1=0x00 -> done high between edges 0 and 1; q=0xFF, r=0x2A, dz=1. A following 0x10/0x04 -> q=0x04, r=0x00, dz=0.
- Start 0x64/0x07, then drive req=1 with a0=0x11, a1=0x02 during RUN:
  - Result is still q=0x0E.
  - The new request is accepted on edge 10 and gives q=0x08, r=0x01.
- Assert rst at edge 4 of a RUN -> done stays 0; q=0, r=0, ready=1 immediately. The next request completes normally.
- Build without SP1_DIV_REM_EN, run 0x64/0x07 -> q=0x0E, r=0x00, same latency.

Source files
------------

// File: rtl/sp1_div.sv
// rtl/sp1_div.sv - iterative unsigned restoring divider, one quotient bit per clock
// Define SP1_DIV_REM_EN to build the remainder register; otherwise r is tied to zero.
module sp1_div #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic [DW-1:0] a0,
   input  logic [DW-1:0] a1,
   output logic          ready,
   output logic          done,
   output logic [DW-1:0] q,
   output logic [DW-1:0] r,
   output logic          dz
);
   localparam int CW = $clog2(DW) + 1;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_dvd;
   logic [DW-1:0] r_dvs;
   logic [DW-1:0] r_p;
   logic [DW-1:0] r_q;
   logic          r_done;
   logic          r_dz;
   logic [DW:0]   w_shift;
   logic [DW:0]   w_t;
   logic          w_borrow;
   logic [DW-1:0] w_p_next;
   logic [DW-1:0] w_dvd_next;

   // P never reaches the divisor, so its top bit is always zero and is not stored;
   // for the same reason a borrow always lands in bit DW of T.
   assign w_shift    = {r_p, r_dvd[DW-1]};
   assign w_t        = w_shift - {1'b0, r_dvs};
   assign w_borrow   = w_t[DW];
   assign w_p_next   = w_borrow ? w_shift[DW-1:0] : w_t[DW-1:0];
   assign w_dvd_next = {r_dvd[DW-2:0], ~w_borrow};

`ifdef SP1_DIV_REM_EN
   logic [DW-1:0] r_r;
   assign r = r_r;
`else
   assign r = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
`ifdef SP1_DIV_REM_EN
         r_r     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_dvd <= a0;
                  r_dvs <= a1;
                  r_p   <= '0;
                  r_cnt <= '0;
                  r_dz  <= 1'b0;
                  if (a1 != '0) begin
                     r_state <= S_RUN;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_q     <= '1;
                     r_dz    <= 1'b1;
`ifdef SP1_DIV_REM_EN
                     r_r     <= a0;
`endif
                  end
               end
            end
            S_RUN: begin
               r_dvd <= w_dvd_next;
               r_p   <= w_p_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_q     <= w_dvd_next;
`ifdef SP1_DIV_REM_EN
                  r_r     <= w_p_next;
`endif
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = (r_state == S_IDLE);
   assign done  = r_done;
   assign q     = r_q;
   assign dz    = r_dz;

endmodule

// File: tb/tb_sp1_div.sv
// tb/tb_sp1_div.sv - randomized and directed bench for sp1_div against a cycle-level model
// Honours SP1_DIV_REM_EN the same way as the design.
module tb_sp1_div;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic [DW-1:0] a0  = '0;
   logic [DW-1:0] a1  = '0;
   logic          ready;
   logic          done;
   logic [DW-1:0] q;
   logic [DW-1:0] r;
   logic          dz;

   int n_checks = 0;
   int n_fail   = 0;

   sp1_div #(.DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .a0    (a0),
      .a1    (a1),
      .ready (ready),
      .done  (done),
      .q     (q),
      .r     (r),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rem_exp(input logic [DW-1:0] v);
`ifdef SP1_DIV_REM_EN
      return v;
`else
      return v & '0;
`endif
   endfunction

   // Model: results from plain division, timing from edge arithmetic.
   int            m_edge       = 0;
   int            m_done_edge  = -1;
   int            m_ready_edge = 0;
   logic          m_ready      = 1'b1;
   logic          m_done       = 1'b0;
   logic [DW-1:0] m_q          = '0;
   logic [DW-1:0] m_r          = '0;
   logic          m_dz         = 1'b0;
   logic [DW-1:0] p_q          = '0;
   logic [DW-1:0] p_r          = '0;
   logic          p_dz         = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edge = 0; m_done_edge = -1; m_ready_edge = 0;
         m_ready = 1'b1; m_done = 1'b0;
         m_q = '0; m_r = '0; m_dz = 1'b0;
      end else begin
         m_edge++;
         if (m_ready && req) begin
            if (a1 == '0) begin
               p_q = '1; p_r = rem_exp(a0); p_dz = 1'b1;
               m_done_edge = m_edge;
            end else begin
               p_q = a0 / a1; p_r = rem_exp(a0 % a1); p_dz = 1'b0;
               m_done_edge = m_edge + DW;
            end
            m_ready_edge = m_done_edge + 1;
         end
         m_ready = (m_edge >= m_ready_edge);
         m_done  = (m_edge == m_done_edge);
         if (m_done) begin
            m_q = p_q; m_r = p_r; m_dz = p_dz;
         end
      end
   end

   always @(negedge clk) begin
      check("ready", 32'(ready), 32'(m_ready));
      check("done", 32'(done), 32'(m_done));
      check("q", 32'(q), 32'(m_q));
      check("r", 32'(r), 32'(m_r));
      if (m_done) check("dz", 32'(dz), 32'(m_dz));
   end

   task automatic run_op(input logic [DW-1:0] x, input logic [DW-1:0] y,
                         output logic [DW-1:0] oq, output logic [DW-1:0] orr,
                         output logic odz, output int lat);
      int n = 0;
      while (!ready && n < 50) begin tick(); n++; end
      check("ready_before_req", 32'(ready), 32'd1);
      req = 1'b1; a0 = x; a1 = y;
      tick();
      req = 1'b0; a0 = DW'($urandom); a1 = DW'($urandom);
      lat = 0;
      while (!done && lat < 40) begin tick(); lat++; end
      check("done_seen", 32'(done), 32'd1);
      oq = q; orr = r; odz = dz;
   endtask

   logic [DW-1:0] t_a0 [6] = '{8'h64, 8'hFF, 8'h05, 8'hFF, 8'h2A, 8'h10};
   logic [DW-1:0] t_a1 [6] = '{8'h07, 8'h01, 8'h09, 8'hFF, 8'h00, 8'h04};
   logic [DW-1:0] t_q  [6] = '{8'h0E, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h04};
   logic [DW-1:0] t_r  [6] = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h2A, 8'h00};
   logic          t_dz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   int            t_lat[6] = '{8, 8, 8, 8, 0, 8};

   initial begin
      logic [DW-1:0] gq, gr;
      logic          gdz;
      int            lat;
      int            lat2;
      logic [DW-1:0] rnd;

      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q", 32'(q), 32'd0);
      check("rst_r", 32'(r), 32'd0);
      check("rst_dz", 32'(dz), 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_op(t_a0[i], t_a1[i], gq, gr, gdz, lat);
         check($sformatf("dir%0d_q", i), 32'(gq), 32'(t_q[i]));
         check($sformatf("dir%0d_r", i), 32'(gr), 32'(rem_exp(t_r[i])));
         check($sformatf("dir%0d_dz", i), 32'(gdz), 32'(t_dz[i]));
         check($sformatf("dir%0d_lat", i), lat, t_lat[i]);
      end

      // request held through RUN is ignored until ready returns
      while (!ready) tick();
      req = 1'b1; a0 = 8'h64; a1 = 8'h07;
      tick();
      a0 = 8'h11; a1 = 8'h02;
      lat = 0;
      while (!done && lat < 40) begin tick(); lat++; end
      check("hold_first_lat", lat, 8);
      check("hold_first_q", 32'(q), 32'h0E);
      lat2 = lat;
      do begin
         tick(); lat2++;
         if (lat2 == 10) req = 1'b0;
      end while (!done && lat2 < 60);
      req = 1'b0;
      check("hold_second_lat", lat2, 18);
      check("hold_second_q", 32'(q), 32'h08);
      check("hold_second_r", 32'(r), 32'(rem_exp(8'h01)));

      // reset in the middle of a RUN
      while (!ready) tick();
      req = 1'b1; a0 = 8'h64; a1 = 8'h07;
      tick();
      req = 1'b0;
      repeat (3) tick();
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_q", 32'(q), 32'd0);
      check("midrst_r", 32'(r), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      repeat (8) tick();
      run_op(8'h64, 8'h07, gq, gr, gdz, lat);
      check("after_rst_q", 32'(gq), 32'h0E);
      check("after_rst_r", 32'(gr), 32'(rem_exp(8'h02)));
      check("after_rst_lat", lat, 8);

      // random traffic, including requests while busy and occasional resets
      repeat (3000) begin
         req = ($urandom_range(0, 3) != 0);
         a0  = DW'($urandom);
         rnd = DW'($urandom);
         case ($urandom_range(0, 7))
            0:       a1 = '0;
            1:       a1 = 8'h01;
            2:       a1 = rnd & 8'h03;
            3:       a1 = 8'hFF;
            default: a1 = rnd;
         endcase
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      req = 1'b0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
